// File: rtl/priority_arbiter.sv
// Shared-resource arbiter: fixed-priority or round-robin selection with a registered
// one-hot grant, release on done/withdrawal, and hold-timer pre-emption.
module priority_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rr_en,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 preempt
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            preempt_q, preempt_d;

  logic [N-1:0]    others, cand;
  logic            hold_exp, pre_c, withdraw, rel, take;
  logic            fix_found, rr_found, found;
  logic [IW-1:0]   win_fix, win_rr, win;
  int unsigned     p, idx;

  always_comb begin
    others   = req & ~grant_q;
    hold_exp = (MAX_HOLD != 0) && (cnt_q == CNT_MAX);
    pre_c    = hold_exp && !done && (|others);
    withdraw = !req[gid_q];
    rel      = (state_q == GRANT) && (done || withdraw || pre_c);
    // On release the outgoing winner is excluded for this one arbitration.
    cand     = rel ? others : req;

    fix_found = 1'b0;
    win_fix   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i]) begin
        fix_found = 1'b1;
        win_fix   = IW'(i);
      end
    end

    rr_found = 1'b0;
    win_rr   = '0;
    p        = 32'(ptr_q);
    idx      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (p >= k) ? (p - k) : (p + N - k);
      if (cand[idx] && !rr_found) begin
        rr_found = 1'b1;
        win_rr   = IW'(idx);
      end
    end

    found = rr_en ? rr_found : fix_found;
    win   = rr_en ? win_rr : win_fix;
    take  = found && ((state_q == IDLE) || rel);

    state_d   = state_q;
    grant_d   = grant_q;
    gid_d     = gid_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    preempt_d = rel && pre_c && !withdraw;

    if (take) begin
      state_d      = GRANT;
      grant_d      = '0;
      grant_d[win] = 1'b1;
      gid_d        = win;
      cnt_d        = '0;
      ptr_d        = (win == '0) ? IW'(N - 1) : win - IW'(1);
    end else if (rel) begin
      state_d = IDLE;
      grant_d = '0;
      gid_d   = '0;
      cnt_d   = '0;
    end else if ((state_q == GRANT) && (MAX_HOLD != 0) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gid_q     <= '0;
      ptr_q     <= IW'(N - 1);
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gid_q     <= gid_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = gid_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Randomized and directed bench for priority_arbiter against a cycle-count
// reference model of the arbitration rules.
module tb_priority_arbiter;

  localparam int N        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk;
  logic         reset_n;
  logic         rr_en;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [2:0]   grant_id;
  logic         preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: held counts cycles since the grant began (1 after grant edge)
  bit m_busy;
  int m_id;
  int m_ptr;
  int m_held;
  bit m_pre;

  priority_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rr_en      (rr_en),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_id   = 0;
    m_ptr  = N - 1;
    m_held = 0;
    m_pre  = 0;
  endtask

  function automatic int pick(input logic [N-1:0] c);
    if (!rr_en) begin
      for (int i = N - 1; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int s = 0; s < N; s++) begin
        int ix;
        ix = (m_ptr - s + N) % N;
        if (c[ix]) return ix;
      end
    end
    return -1;
  endfunction

  task automatic new_grant(input int w);
    m_busy = 1;
    m_id   = w;
    m_held = 1;
    m_ptr  = (w + N - 1) % N;
  endtask

  task automatic model_step();
    logic [N-1:0] masked;
    bit wd, pre;
    int w;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_pre = 0;
    if (m_busy) begin
      masked = req;
      masked[m_id] = 1'b0;
      wd  = !req[m_id];
      pre = (MAX_HOLD != 0) && (m_held >= MAX_HOLD) && !done && (masked != 0);
      if (done || wd || pre) begin
        m_pre = pre && !wd;
        w = pick(masked);
        if (w >= 0) new_grant(w);
        else begin
          m_busy = 0;
          m_id   = 0;
        end
      end else begin
        m_held++;
      end
    end else begin
      w = pick(req);
      if (w >= 0) new_grant(w);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = '0;
    if (m_busy) eg[m_id] = 1'b1;
    check("grant", 32'(grant), 32'(eg));
    check("grant_valid", 32'(grant_valid), 32'(m_busy));
    check("grant_id", 32'(grant_id), m_busy ? m_id : 0);
    check("preempt", 32'(preempt), 32'(m_pre));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    reset_n = 1'b0;
    rr_en   = 1'b0;
    req     = '0;
    done    = 1'b0;
    model_reset();
    repeat (2) cycle();
    check("reset_grant", 32'(grant), 0);
    check("reset_id", 32'(grant_id), 0);
    reset_n = 1'b1;

    repeat (10) begin
      cycle();
      check("idle_valid", 32'(grant_valid), 0);
      check("idle_preempt", 32'(preempt), 0);
    end

    // fixed priority then back-to-back release on done
    req = 8'b0010_0100;
    cycle();
    check("fp_grant", 32'(grant), 32'h20);
    check("fp_id", 32'(grant_id), 5);
    done = 1'b1;
    cycle();
    done = 1'b0;
    check("fp_b2b_grant", 32'(grant), 32'h04);
    check("fp_b2b_id", 32'(grant_id), 2);

    // withdrawal: hold 6 past the hold limit with nobody waiting, then drop it
    req = 8'b0100_0000;
    repeat (7) begin
      cycle();
      check("wd_hold_id", 32'(grant_id), 6);
      check("wd_hold_pre", 32'(preempt), 0);
    end
    req = '0;
    cycle();
    check("wd_grant", 32'(grant), 0);
    check("wd_preempt", 32'(preempt), 0);

    // pre-emption ping-pong between 3 and 1
    req = 8'b0000_1010;
    repeat (MAX_HOLD) begin
      cycle();
      check("pe_hold3", 32'(grant_id), 3);
    end
    cycle();
    check("pe_id1", 32'(grant_id), 1);
    check("pe_pulse1", 32'(preempt), 1);
    repeat (MAX_HOLD - 1) begin
      cycle();
      check("pe_hold1", 32'(grant_id), 1);
      check("pe_nopulse", 32'(preempt), 0);
    end
    cycle();
    check("pe_id3", 32'(grant_id), 3);
    check("pe_pulse2", 32'(preempt), 1);

    // asynchronous reset between edges while granted and preempt high
    #2 reset_n = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 0);
    check("ar_valid", 32'(grant_valid), 0);
    check("ar_id", 32'(grant_id), 0);
    check("ar_preempt", 32'(preempt), 0);
    model_reset();
    req = '0;
    cycle();
    reset_n = 1'b1;

    // round-robin from the reset pointer
    rr_en = 1'b1;
    req   = 8'hFF;
    done  = 1'b1;
    for (int s = 0; s < 9; s++) begin
      cycle();
      check("rr_seq", 32'(grant_id), (7 - s + 8) % 8);
    end
    done = 1'b0;
    req  = '0;
    cycle();

    // randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      else if ($urandom_range(0, 5) == 0) req[$urandom_range(0, N - 1)] = ~req[$urandom_range(0, N - 1)];
      done = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 40) == 0) rr_en = ~rr_en;
      reset_n = ($urandom_range(0, 300) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
